// File: rtl/ib_seq_ctrl_if.sv
// Handshake/control bundle between the job issuer, the input-vector buffer and ib_seq_ctrl.
// The controller connects through the slave modport; the issuer/bench uses master.
interface ib_seq_ctrl_if #(
    parameter int REP_W = 8
);
    logic             start;
    logic [REP_W-1:0] reps;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ib_ctl;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        output start, reps, in_valid,
        input  in_ready, ib_ctl, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, reps, in_valid,
        output in_ready, ib_ctl, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/ib_seq_ctrl.sv
// Load/replay sequencer driving the 2-bit control of one input-vector buffer.
// Optional abort input enabled by defining IB_SEQ_CTRL_ABORT_EN.
module ib_seq_ctrl #(
    parameter int VECTOR = 4,
    parameter int REP_W  = 8
) (
    input logic clk,
    input logic rst,
`ifdef IB_SEQ_CTRL_ABORT_EN
    input logic abort,
`endif
    ib_seq_ctrl_if.slave bus
);

    localparam logic [1:0]       CTL_IDLE  = 2'd0;
    localparam logic [1:0]       CTL_STORE = 2'd1;
    localparam logic [1:0]       CTL_OUT   = 2'd2;
    localparam logic [1:0]       CTL_HOLD  = 2'd3;
    localparam logic [7:0]       WLAST     = 8'(VECTOR - 1);
    localparam logic [REP_W-1:0] REP_ZERO  = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GAP  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // A zero replay count still replays the vector once.
    function automatic logic [REP_W-1:0] clamp_reps(input logic [REP_W-1:0] r);
        clamp_reps = (r == REP_ZERO) ? REP_ONE : r;
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       wcnt_r, wcnt_s;
    logic [REP_W-1:0] rcnt_r, rcnt_s;
    logic [REP_W-1:0] reps_r, reps_s;
    logic             out_valid_r, out_last_r;
    logic [1:0]       ctl_s;
    logic             ready_s;
    logic             done_s;
    logic             last_s;
    logic             abort_s;

`ifdef IB_SEQ_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state, counter and buffer-control decode.
    always_comb begin
        state_s = state_r;
        wcnt_s  = wcnt_r;
        rcnt_s  = rcnt_r;
        reps_s  = reps_r;
        ctl_s   = CTL_IDLE;
        ready_s = 1'b0;
        done_s  = 1'b0;
        last_s  = 1'b0;
        if (abort_s && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
            wcnt_s  = 8'd0;
            rcnt_s  = REP_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        reps_s  = clamp_reps(bus.reps);
                        wcnt_s  = 8'd0;
                        rcnt_s  = REP_ZERO;
                        state_s = S_LOAD;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    ready_s = 1'b1;
                    // Holding (3) rather than idling (0) keeps the buffer address intact.
                    if (bus.in_valid) begin
                        ctl_s = CTL_STORE;
                        if (wcnt_r == WLAST) begin
                            wcnt_s  = 8'd0;
                            state_s = S_GAP;
                        end else begin
                            wcnt_s = wcnt_r + 8'd1;
                        end
                    end else begin
                        ctl_s = CTL_HOLD;
                    end
                end
                S_GAP: begin
                    state_s = S_SEND;
                end
                S_SEND: begin
                    ctl_s = CTL_OUT;
                    if (wcnt_r == WLAST) begin
                        wcnt_s = 8'd0;
                        if (rcnt_r == (reps_r - REP_ONE)) begin
                            last_s  = 1'b1;
                            state_s = S_DONE;
                        end else begin
                            rcnt_s  = rcnt_r + REP_ONE;
                            state_s = S_GAP;
                        end
                    end else begin
                        wcnt_s = wcnt_r + 8'd1;
                    end
                end
                S_DONE: begin
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                    wcnt_s  = 8'd0;
                    rcnt_s  = REP_ZERO;
                end
            endcase
        end
    end

    // State/counter registers; out_valid/out_last track the buffer's registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            wcnt_r      <= 8'd0;
            rcnt_r      <= REP_ZERO;
            reps_r      <= REP_ZERO;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            wcnt_r      <= wcnt_s;
            rcnt_r      <= rcnt_s;
            reps_r      <= reps_s;
            out_valid_r <= (ctl_s == CTL_OUT);
            out_last_r  <= last_s;
        end
    end

    assign bus.ib_ctl    = ctl_s;
    assign bus.in_ready  = ready_s;
    assign bus.busy      = (state_r != S_IDLE);
    assign bus.done      = done_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_ib_seq_ctrl.sv
// Directed bench for ib_seq_ctrl (VECTOR=4) with a behavioural store/out/idle buffer attached.
// Define IB_SEQ_CTRL_ABORT_EN for both RTL and bench to exercise the abort path.
module tb_ib_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din;
    logic [7:0] buf_mem [0:7];
    logic [2:0] buf_addr;
    logic [7:0] buf_dout;
    logic [31:0] va, vb, vc, vd, ve;
    int checks = 0;
    int errors = 0;
`ifdef IB_SEQ_CTRL_ABORT_EN
    logic abort_i = 1'b0;
`endif

    ib_seq_ctrl_if #(.REP_W(8)) bus_i ();

    ib_seq_ctrl #(.VECTOR(4), .REP_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef IB_SEQ_CTRL_ABORT_EN
        .abort (abort_i),
`endif
        .bus   (bus_i)
    );

    always #5 clk = ~clk;

    // Input-vector buffer: 0 resets address, 1 stores, 2 reads to a registered output, 3 holds.
    always @(posedge clk) begin
        case (bus_i.ib_ctl)
            2'd0: buf_addr <= 3'd0;
            2'd1: begin buf_mem[buf_addr] <= din; buf_addr <= buf_addr + 3'd1; end
            2'd2: begin buf_dout <= buf_mem[buf_addr]; buf_addr <= buf_addr + 3'd1; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs (inputs already driven), then advance to the next cycle.
    task automatic cyc(input string tag, input logic [1:0] e_ctl, input logic e_rdy,
                       input logic e_busy, input logic e_ov, input logic e_ol,
                       input logic e_dn, input logic [7:0] e_d);
        #1;
        chk($sformatf("%s ib_ctl", tag), bus_i.ib_ctl, e_ctl);
        chk($sformatf("%s in_ready", tag), bus_i.in_ready, e_rdy);
        chk($sformatf("%s busy", tag), bus_i.busy, e_busy);
        chk($sformatf("%s out_valid", tag), bus_i.out_valid, e_ov);
        chk($sformatf("%s out_last", tag), bus_i.out_last, e_ol);
        chk($sformatf("%s done", tag), bus_i.done, e_dn);
        if (e_ov) chk($sformatf("%s data", tag), buf_dout, e_d);
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input string tag, input logic [7:0] r);
        bus_i.start    = 1'b1;
        bus_i.reps     = r;
        bus_i.in_valid = 1'b1;
        din            = 8'hEE;
        cyc(tag, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // pat is LSB-first: bit i is in_valid for load cycle i.
    task automatic load(input string tag, input logic [31:0] v, input logic [15:0] pat, input int len);
        int k;
        k = 0;
        for (int i = 0; i < len; i++) begin
            bus_i.start    = 1'b0;
            bus_i.reps     = 8'hFF;
            bus_i.in_valid = pat[i];
            din            = pat[i] ? v[8*k +: 8] : 8'hEE;
            cyc($sformatf("%s c%0d", tag, i), pat[i] ? 2'd1 : 2'd3,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (pat[i]) k++;
        end
    endtask

    // GAP + 4 SEND per replay, then DONE and one IDLE cycle; in_valid held high to show it is ignored.
    task automatic replays(input string tag, input int r_n, input logic [31:0] v, input logic pulse_start);
        for (int r = 0; r < r_n; r++) begin
            bus_i.start    = 1'b0;
            bus_i.in_valid = 1'b1;
            din            = 8'hEE;
            cyc($sformatf("%s r%0d gap", tag, r), 2'd0, 1'b0, 1'b1, (r > 0), 1'b0, 1'b0, v[31:24]);
            for (int w = 0; w < 4; w++) begin
                bus_i.start = pulse_start && (r == 0) && (w == 1);
                cyc($sformatf("%s r%0d send%0d", tag, r, w), 2'd2, 1'b0, 1'b1, (w > 0),
                    1'b0, 1'b0, v[8*((w + 3) % 4) +: 8]);
            end
        end
        bus_i.start = 1'b0;
        cyc($sformatf("%s done", tag), 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, v[31:24]);
        cyc($sformatf("%s idle", tag), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        va = 32'h44332211;
        vb = 32'hD4C3B2A1;
        vc = 32'h0F0E0D0C;
        vd = 32'h99887766;
        ve = 32'h5A6B7C8D;
        bus_i.start    = 1'b1;
        bus_i.reps     = 8'd3;
        bus_i.in_valid = 1'b1;
        din            = 8'h00;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            cyc($sformatf("reset c%0d", i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst            = 1'b1;
        bus_i.start    = 1'b0;
        bus_i.in_valid = 1'b0;
        cyc("post-reset idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Basic job: reps=1, continuous load.
        kick("basic kick", 8'd1);
        load("basic load", va, 16'h000F, 4);
        replays("basic", 1, va, 1'b0);

        // Gapped load 1,0,1,0,0,1,1.
        kick("gapped kick", 8'd1);
        load("gapped load", vb, 16'h0065, 7);
        replays("gapped", 1, vb, 1'b0);

        // Three replays of one vector.
        kick("reps3 kick", 8'd3);
        load("reps3 load", vc, 16'h000F, 4);
        replays("reps3", 3, vc, 1'b0);

        // reps=0 acts as 1; start pulsed during SEND is ignored.
        kick("reps0 kick", 8'd0);
        load("reps0 load", vd, 16'h000F, 4);
        replays("reps0", 1, vd, 1'b1);
        bus_i.in_valid = 1'b0;
        cyc("reps0 no restart", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef IB_SEQ_CTRL_ABORT_EN
        kick("abort kick", 8'd2);
        load("abort load", ve, 16'h000F, 4);
        bus_i.in_valid = 1'b0;
        cyc("abort gap", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("abort send0", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        abort_i = 1'b1;
        cyc("abort cycle", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ve[7:0]);
        abort_i = 1'b0;
        cyc("abort idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("abort idle2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        kick("after-abort kick", 8'd1);
        load("after-abort load", va, 16'h000F, 4);
        replays("after-abort", 1, va, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
